// File: rtl/combat_resolver_if.sv
// Signal bundle between the player FSMs/HUD side and the combat resolver.
// The master side drives positions and states; the resolver (slave) returns health, stun and match result.
interface combat_resolver_if;
    logic [9:0] p1_x;
    logic [9:0] p2_x;
    logic [3:0] p1_state;
    logic [3:0] p2_state;
    logic       p1_dir_attacking;
    logic       p2_dir_attacking;
    logic [1:0] p1_health;
    logic [1:0] p2_health;
    logic       p1_hitstun;
    logic       p2_hitstun;
    logic       p1_blockstun;
    logic       p2_blockstun;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output p1_x, p2_x, p1_state, p2_state, p1_dir_attacking, p2_dir_attacking,
        input  p1_health, p2_health, p1_hitstun, p2_hitstun,
        input  p1_blockstun, p2_blockstun, game_over, winner
    );

    modport slave (
        input  p1_x, p2_x, p1_state, p2_state, p1_dir_attacking, p2_dir_attacking,
        output p1_health, p2_health, p1_hitstun, p2_hitstun,
        output p1_blockstun, p2_blockstun, game_over, winner
    );
endinterface

// File: rtl/combat_resolver.sv
// Per-frame hit/block resolution, damage, stun counters and match-winner FSM for a two-player fighter.
// Index 0 is P1 (left), index 1 is P2 (right); every attacker i targets defender 1-i.
module combat_resolver #(
    parameter int SPRITE_W      = 64,
    parameter int REACH_NEUTRAL = 24,
    parameter int REACH_DIR     = 32,
    parameter int HITSTUN_FR    = 16,
    parameter int BLOCKSTUN_FR  = 10,
    parameter int MAX_HEALTH    = 3
) (
    input  logic               clk,
    input  logic               reset,
    combat_resolver_if.slave   bus
);

    localparam int STUN_MAX = (HITSTUN_FR > BLOCKSTUN_FR) ? HITSTUN_FR : BLOCKSTUN_FR;
    localparam int CNT_W    = $clog2(STUN_MAX + 1);

    localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(HITSTUN_FR);
    localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCKSTUN_FR);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [10:0]      REACH_N    = 11'(REACH_NEUTRAL);
    localparam logic [10:0]      REACH_D    = 11'(REACH_DIR);
    localparam logic [1:0]       HEALTH_INIT = 2'(MAX_HEALTH);

    localparam logic [3:0] ST_MOVE_BWD   = 4'd2;
    localparam logic [3:0] ST_ATTACK_ACT = 4'd6;

    typedef enum logic {
        S_FIGHT,
        S_GAME_OVER
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       winner_q, winner_d;
    logic [1:0]       health_q [2];
    logic [1:0]       health_d [2];
    logic [CNT_W-1:0] hit_q    [2];
    logic [CNT_W-1:0] hit_d    [2];
    logic [CNT_W-1:0] blk_q    [2];
    logic [CNT_W-1:0] blk_d    [2];
    logic             latch_q  [2];
    logic             latch_d  [2];

    logic [3:0]  pstate [2];
    logic        pdir   [2];
    logic [10:0] reach  [2];
    logic        connect [2];
    logic        blocking [2];
    logic [10:0] p1_right;
    logic [10:0] p2_left;
    logic [10:0] gap;

    assign pstate[0] = bus.p1_state;
    assign pstate[1] = bus.p2_state;
    assign pdir[0]   = bus.p1_dir_attacking;
    assign pdir[1]   = bus.p2_dir_attacking;

    // Distance between P1's right edge and P2's left edge; overlap clamps to zero.
    assign p1_right = {1'b0, bus.p1_x} + 11'(SPRITE_W);
    assign p2_left  = {1'b0, bus.p2_x};
    assign gap      = (p2_left < p1_right) ? 11'd0 : (p2_left - p1_right);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            reach[i]   = pdir[i] ? REACH_D : REACH_N;
            connect[i] = (state_q == S_FIGHT) && (pstate[i] == ST_ATTACK_ACT) &&
                         (gap <= reach[i]) && !latch_q[i];
            // A stunned defender cannot block, even when holding back.
            blocking[i] = (pstate[1-i] == ST_MOVE_BWD) &&
                          (hit_q[1-i] == '0) && (blk_q[1-i] == '0);
        end
    end

    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        for (int i = 0; i < 2; i++) begin
            health_d[i] = health_q[i];
            hit_d[i]    = (hit_q[i] != '0) ? (hit_q[i] - CNT_ONE) : '0;
            blk_d[i]    = (blk_q[i] != '0) ? (blk_q[i] - CNT_ONE) : '0;
            latch_d[i]  = (pstate[i] == ST_ATTACK_ACT) ? (latch_q[i] | connect[i]) : 1'b0;
        end

        // Both attackers resolve independently, so a trade damages both players in one frame.
        for (int i = 0; i < 2; i++) begin
            if (connect[i]) begin
                if (blocking[i]) begin
                    blk_d[1-i] = BLOCK_LOAD;
                end else begin
                    health_d[1-i] = (health_q[1-i] != 2'd0) ? (health_q[1-i] - 2'd1) : 2'd0;
                    hit_d[1-i]    = HIT_LOAD;
                    blk_d[1-i]    = '0;
                end
            end
        end

        case (state_q)
            S_FIGHT: begin
                if (health_d[0] == 2'd0 || health_d[1] == 2'd0) begin
                    state_d = S_GAME_OVER;
                    if (health_d[0] == 2'd0 && health_d[1] == 2'd0) winner_d = 2'd3;
                    else if (health_d[1] == 2'd0)                   winner_d = 2'd1;
                    else                                            winner_d = 2'd2;
                end
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default:     state_d = S_FIGHT;
        endcase

        // Once the match is decided nobody stays stunned.
        if (state_d == S_GAME_OVER) begin
            for (int i = 0; i < 2; i++) begin
                hit_d[i] = '0;
                blk_d[i] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FIGHT;
            winner_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                health_q[i] <= HEALTH_INIT;
                hit_q[i]    <= '0;
                blk_q[i]    <= '0;
                latch_q[i]  <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            for (int i = 0; i < 2; i++) begin
                health_q[i] <= health_d[i];
                hit_q[i]    <= hit_d[i];
                blk_q[i]    <= blk_d[i];
                latch_q[i]  <= latch_d[i];
            end
        end
    end

    assign bus.p1_health    = health_q[0];
    assign bus.p2_health    = health_q[1];
    assign bus.p1_hitstun   = (hit_q[0] != '0);
    assign bus.p2_hitstun   = (hit_q[1] != '0);
    assign bus.p1_blockstun = (blk_q[0] != '0);
    assign bus.p2_blockstun = (blk_q[1] != '0);
    assign bus.game_over    = (state_q == S_GAME_OVER);
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Self-checking bench for combat_resolver: a table of single-frame reach/block vectors
// plus hand-written multi-frame sequences, all checked through an expectation queue.
module tb_combat_resolver;

    logic clk;
    logic reset;

    combat_resolver_if bus ();

    combat_resolver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Packed outputs: {p1_health, p2_health, p1_hs, p2_hs, p1_bs, p2_bs, game_over, winner}
    typedef struct {
        logic [10:0] v;
        bit          chk_stun;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [9:0] x1;
        logic [9:0] x2;
        logic       d1;
        logic [3:0] s2;
        logic [1:0] h2;
        logic       hs2;
        logic       bs2;
        string      name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [10:0] mk(input logic [1:0] h1, input logic [1:0] h2,
                                       input logic hs1, input logic hs2,
                                       input logic bs1, input logic bs2,
                                       input logic go,  input logic [1:0] win);
        return {h1, h2, hs1, hs2, bs1, bs2, go, win};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.p1_health, bus.p2_health, bus.p1_hitstun, bus.p2_hitstun,
                bus.p1_blockstun, bus.p2_blockstun, bus.game_over, bus.winner};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [9:0] x1, input logic [9:0] x2,
                         input logic [3:0] s1, input logic [3:0] s2,
                         input logic d1, input logic d2);
        bus.p1_x             = x1;
        bus.p2_x             = x2;
        bus.p1_state         = s1;
        bus.p2_state         = s2;
        bus.p1_dir_attacking = d1;
        bus.p2_dir_attacking = d2;
    endtask

    // One frame: drive on the falling edge, queue the expectation, compare just after the rising edge.
    task automatic step(input logic [9:0] x1, input logic [9:0] x2,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic d1, input logic d2,
                        input logic [10:0] e, input bit chk_stun, input string name);
        exp_t got;
        logic [10:0] mask;
        @(negedge clk);
        drive(x1, x2, s1, s2, d1, d2);
        sb.push_back('{e, chk_stun, name});
        @(posedge clk);
        #1;
        got  = sb.pop_front();
        mask = got.chk_stun ? 11'h7ff : 11'b111_1000_0111;
        check(got.name, outs() & mask, got.v & mask);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0);
        #1;
        check("reset_state", outs(), mk(2'd3, 2'd3, 0, 0, 0, 0, 0, 2'd0));

        // Single P1 attack frame from reset; p1_x=100 puts P1's right edge at 164.
        vecs[0]  = '{10'd100, 10'd180, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, "gap16_neutral_hit"};
        vecs[1]  = '{10'd100, 10'd180, 1'b0, 4'd2, 2'd3, 1'b0, 1'b1, "gap16_blocked"};
        vecs[2]  = '{10'd100, 10'd192, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0, "gap28_neutral_miss"};
        vecs[3]  = '{10'd100, 10'd192, 1'b1, 4'd0, 2'd2, 1'b1, 1'b0, "gap28_dir_hit"};
        vecs[4]  = '{10'd100, 10'd188, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, "gap24_neutral_edge_hit"};
        vecs[5]  = '{10'd100, 10'd189, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0, "gap25_neutral_miss"};
        vecs[6]  = '{10'd100, 10'd196, 1'b1, 4'd0, 2'd2, 1'b1, 1'b0, "gap32_dir_edge_hit"};
        vecs[7]  = '{10'd100, 10'd197, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0, "gap33_dir_miss"};
        vecs[8]  = '{10'd300, 10'd350, 1'b0, 4'd0, 2'd2, 1'b1, 1'b0, "overlap_clamp_hit"};
        vecs[9]  = '{10'd100, 10'd180, 1'b0, 4'd9, 2'd2, 1'b1, 1'b0, "state9_no_block"};
        vecs[10] = '{10'd0,   10'd1023, 1'b1, 4'd0, 2'd3, 1'b0, 1'b0, "far_apart_miss"};
        vecs[11] = '{10'd100, 10'd180, 1'b0, 4'd8, 2'd2, 1'b1, 1'b0, "state8_no_block"};

        for (int v = 0; v < 12; v++) begin
            do_reset();
            step(vecs[v].x1, vecs[v].x2, 4'd6, vecs[v].s2, vecs[v].d1, 1'b0,
                 mk(2'd3, vecs[v].h2, 0, vecs[v].hs2, 0, vecs[v].bs2, 0, 2'd0), 1'b1, vecs[v].name);
        end

        // Two ACT frames give one hit; hitstun stays high for exactly 16 frames.
        do_reset();
        for (int k = 1; k <= 20; k++)
            step(10'd100, 10'd180, (k <= 2) ? 4'd6 : 4'd0, 4'd0, 1'b0, 1'b0,
                 mk(2'd3, 2'd2, 0, (k <= 16), 0, 0, 0, 2'd0), 1'b1, $sformatf("hitstun_f%0d", k));

        // Blocked attack: 10 frames of blockstun, no damage, no hitstun.
        do_reset();
        for (int k = 1; k <= 12; k++)
            step(10'd100, 10'd180, (k <= 2) ? 4'd6 : 4'd0, (k <= 2) ? 4'd2 : 4'd0, 1'b0, 1'b0,
                 mk(2'd3, 2'd3, 0, 0, 0, (k <= 10), 0, 2'd0), 1'b1, $sformatf("blockstun_f%0d", k));

        // Holding back while already in blockstun does not block a second attack.
        do_reset();
        step(10'd100, 10'd180, 4'd6, 4'd2, 1'b0, 1'b0, mk(2'd3, 2'd3, 0, 0, 0, 1, 0, 2'd0), 1'b1, "bs_first_block");
        step(10'd100, 10'd180, 4'd0, 4'd2, 1'b0, 1'b0, mk(2'd3, 2'd3, 0, 0, 0, 1, 0, 2'd0), 1'b1, "bs_hold");
        step(10'd100, 10'd180, 4'd6, 4'd2, 1'b0, 1'b0, mk(2'd3, 2'd2, 0, 1, 0, 0, 0, 2'd0), 1'b1, "bs_no_block_in_stun");

        // Trade at overlap: both take damage and both enter hitstun.
        do_reset();
        step(10'd300, 10'd350, 4'd6, 4'd6, 1'b0, 1'b0, mk(2'd2, 2'd2, 1, 1, 0, 0, 0, 2'd0), 1'b1, "trade_both_hit");

        // Three P1 hits end the match; a later P2 attack changes nothing.
        do_reset();
        step(10'd100, 10'd180, 4'd6, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd2, 0, 1, 0, 0, 0, 2'd0), 1'b1, "ko_hit1");
        step(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd2, 0, 1, 0, 0, 0, 2'd0), 1'b1, "ko_gap1");
        step(10'd100, 10'd180, 4'd6, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd1, 0, 1, 0, 0, 0, 2'd0), 1'b1, "ko_hit2_reload");
        step(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd1, 0, 1, 0, 0, 0, 2'd0), 1'b1, "ko_gap2");
        step(10'd100, 10'd180, 4'd6, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd0, 0, 0, 0, 0, 1, 2'd1), 1'b0, "ko_hit3_p1_wins");
        step(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd0, 0, 0, 0, 0, 1, 2'd1), 1'b0, "ko_settle");
        for (int k = 1; k <= 4; k++)
            step(10'd100, 10'd180, 4'd0, (k <= 2) ? 4'd6 : 4'd0, 1'b0, 1'b0,
                 mk(2'd3, 2'd0, 0, 0, 0, 0, 1, 2'd1), 1'b1, $sformatf("ko_frozen_f%0d", k));

        // Three trades: both reach zero on the same frame, a draw.
        do_reset();
        for (int t = 1; t <= 2; t++) begin
            step(10'd300, 10'd350, 4'd6, 4'd6, 1'b0, 1'b0,
                 mk(2'(3 - t), 2'(3 - t), 1, 1, 0, 0, 0, 2'd0), 1'b1, $sformatf("draw_trade%0d", t));
            step(10'd300, 10'd350, 4'd0, 4'd0, 1'b0, 1'b0,
                 mk(2'(3 - t), 2'(3 - t), 1, 1, 0, 0, 0, 2'd0), 1'b1, $sformatf("draw_gap%0d", t));
        end
        step(10'd300, 10'd350, 4'd6, 4'd6, 1'b0, 1'b0, mk(2'd0, 2'd0, 0, 0, 0, 0, 1, 2'd3), 1'b0, "draw_final");
        step(10'd300, 10'd350, 4'd0, 4'd0, 1'b0, 1'b0, mk(2'd0, 2'd0, 0, 0, 0, 0, 1, 2'd3), 1'b0, "draw_settle");
        step(10'd300, 10'd350, 4'd6, 4'd6, 1'b0, 1'b0, mk(2'd0, 2'd0, 0, 0, 0, 0, 1, 2'd3), 1'b1, "draw_frozen");

        // Asynchronous reset in the middle of hitstun returns everything to reset values at once.
        do_reset();
        step(10'd100, 10'd180, 4'd6, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd2, 0, 1, 0, 0, 0, 2'd0), 1'b1, "mid_hit");
        step(10'd100, 10'd180, 4'd0, 4'd0, 1'b0, 1'b0, mk(2'd3, 2'd2, 0, 1, 0, 0, 0, 2'd0), 1'b1, "mid_stun");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_reset_mid_stun", outs(), mk(2'd3, 2'd3, 0, 0, 0, 0, 0, 2'd0));
        @(negedge clk);
        reset = 1'b0;

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
